axi_stream_slave: RTL and testbench

AXI4-Stream receive stage for the message-authentication datapath. It accepts beats from an upstream `axi_stream_master` and buffers them in a small FIFO. Each beat is tagged with its valid-byte count and an end-of-message flag. The block enforces a maximum message length and presents the beats to the internal consumer (hash/MAC core) through a simple valid/pop interface.

---
 rtl/axis_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/axi_stream_slave.sv | 146 ++++++++++++++
 tb/tb_axi_stream_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI4-Stream receive stage.
package axis_pkg;

  localparam int unsigned AXIS_DATA_W  = 512;
  localparam int unsigned AXIS_KEEP_W  = AXIS_DATA_W / 8;
  localparam int unsigned AXIS_BYTES_W = $clog2(AXIS_KEEP_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } st_e;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0]  data;
    logic [AXIS_BYTES_W-1:0] bytes;
    logic                    last;
    logic                    err;
  } axis_entry_t;

  // Number of set byte enables; tkeep is expected to be contiguous from bit 0.
  function automatic logic [AXIS_BYTES_W-1:0] keep_popcount(input logic [AXIS_KEEP_W-1:0] keep);
    logic [AXIS_BYTES_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < AXIS_KEEP_W; i++) begin
      cnt = cnt + AXIS_BYTES_W'(keep[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; head entry is read straight from the storage registers.
module sync_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign do_push_c = push && !full;
  assign do_pop_c  = pop && !empty;
  assign dout      = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; simultaneous push and pop keeps occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push_c, do_pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointer registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push_c) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/axi_stream_slave.sv
// AXI4-Stream receive stage: tags beats with byte count / end flag, limits message length, buffers for the consumer.
module axi_stream_slave
  import axis_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = AXIS_DATA_W,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MAX_BEATS   = 16
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             tvalid,
  output logic                             tready,
  input  logic [TDATA_WIDTH-1:0]           tdata,
  input  logic [TDATA_WIDTH/8-1:0]         tkeep,
  input  logic                             tlast,
  output logic                             rd_valid,
  output logic [TDATA_WIDTH-1:0]           rd_data,
  output logic [$clog2(TDATA_WIDTH/8):0]   rd_bytes,
  output logic                             rd_last,
  output logic                             rd_err,
  input  logic                             rd_en,
  output logic [15:0]                      msg_count,
  output logic                             err_overlong,
  input  logic                             err_clr
);

  localparam int unsigned BCNT_W = $clog2(MAX_BEATS + 1);

  st_e               state_q, state_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BCNT_W-1:0] beat_nxt_c;
  logic [15:0]       msg_count_q, msg_count_d;
  logic              err_overlong_q, err_overlong_d;

  logic              accept_c;
  logic              push_c;
  logic              pop_c;
  axis_entry_t       wr_entry_c;
  axis_entry_t       head_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;

  // Ready depends only on registered state, never on tvalid.
  assign tready   = (state_q == DROP) || !fifo_full_c;
  assign accept_c = tvalid && tready;
  assign pop_c    = rd_en && !fifo_empty_c;

  // Message framing: tags each accepted beat and decides whether it is stored or dropped.
  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    msg_count_d    = msg_count_q;
    err_overlong_d = err_overlong_q;
    push_c         = 1'b0;
    beat_nxt_c     = beat_cnt_q + BCNT_W'(1);
    wr_entry_c     = '{data: tdata, bytes: keep_popcount(tkeep), last: 1'b0, err: 1'b0};

    if (err_clr) err_overlong_d = 1'b0;

    if (accept_c) begin
      unique case (state_q)
        IDLE: begin
          push_c = 1'b1;
          if (tlast) begin
            wr_entry_c.last = 1'b1;
            msg_count_d     = msg_count_q + 16'd1;
          end else if (MAX_BEATS == 1) begin
            wr_entry_c.last = 1'b1;
            wr_entry_c.err  = 1'b1;
            err_overlong_d  = 1'b1;
            msg_count_d     = msg_count_q + 16'd1;
            beat_cnt_d      = '0;
            state_d         = DROP;
          end else begin
            beat_cnt_d = BCNT_W'(1);
            state_d    = BODY;
          end
        end
        BODY: begin
          push_c = 1'b1;
          if (tlast) begin
            wr_entry_c.last = 1'b1;
            msg_count_d     = msg_count_q + 16'd1;
            beat_cnt_d      = '0;
            state_d         = IDLE;
          end else if (beat_nxt_c == BCNT_W'(MAX_BEATS)) begin
            // Limit reached without an end marker: close the message here, discard the rest.
            wr_entry_c.last = 1'b1;
            wr_entry_c.err  = 1'b1;
            err_overlong_d  = 1'b1;
            msg_count_d     = msg_count_q + 16'd1;
            beat_cnt_d      = '0;
            state_d         = DROP;
          end else begin
            beat_cnt_d = beat_nxt_c;
          end
        end
        DROP: begin
          if (tlast) state_d = IDLE;
        end
        default: begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      endcase
    end
  end

  // Framing state, counters and sticky error flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      beat_cnt_q     <= '0;
      msg_count_q    <= '0;
      err_overlong_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      msg_count_q    <= msg_count_d;
      err_overlong_q <= err_overlong_d;
    end
  end

  sync_fifo #(
    .T     (axis_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (push_c),
    .pop   (pop_c),
    .din   (wr_entry_c),
    .dout  (head_c),
    .full  (fifo_full_c),
    .empty (fifo_empty_c)
  );

  assign rd_valid     = !fifo_empty_c;
  assign rd_data      = head_c.data;
  assign rd_bytes     = head_c.bytes;
  assign rd_last      = head_c.last;
  assign rd_err       = head_c.err;
  assign msg_count    = msg_count_q;
  assign err_overlong = err_overlong_q;

endmodule

// File: tb/tb_axi_stream_slave.sv
// Directed bench for axi_stream_slave with an expected-entry queue checked on every pop.
module tb_axi_stream_slave;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         tvalid;
  logic         tready;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;
  logic         rd_valid;
  logic [511:0] rd_data;
  logic [6:0]   rd_bytes;
  logic         rd_last;
  logic         rd_err;
  logic         rd_en;
  logic [15:0]  msg_count;
  logic         err_overlong;
  logic         err_clr;

  typedef struct {
    logic [511:0] data;
    logic [6:0]   bytes;
    logic         last;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_n  = 0;
  int   tick_n = 0;

  localparam logic [63:0] KEEP_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  axi_stream_slave #(
    .TDATA_WIDTH (512),
    .DEPTH       (4),
    .MAX_BEATS   (16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .tvalid       (tvalid),
    .tready       (tready),
    .tdata        (tdata),
    .tkeep        (tkeep),
    .tlast        (tlast),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_bytes     (rd_bytes),
    .rd_last      (rd_last),
    .rd_err       (rd_err),
    .rd_en        (rd_en),
    .msg_count    (msg_count),
    .err_overlong (err_overlong),
    .err_clr      (err_clr)
  );

  always #5 aclk = ~aclk;

  function automatic logic [511:0] pat(input int n);
    return {16{32'hC0DE_0000 + 32'(n)}};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [511:0] d, input logic [6:0] b, input logic l, input logic e);
    exp_t x;
    x.data  = d;
    x.bytes = b;
    x.last  = l;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  // One clock: sample handshakes mid-cycle, then return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge aclk);
    if (rd_valid && rd_en) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL pop_unexpected observed=%0h expected=no_pop", rd_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_data",  rd_data,          e.data);
        check("pop_bytes", 512'(rd_bytes),   512'(e.bytes));
        check("pop_last",  512'(rd_last),    512'(e.last));
        check("pop_err",   512'(rd_err),     512'(e.err));
      end
    end
    if (tvalid && tready) acc_n++;
    @(posedge aclk);
    #1;
    tick_n++;
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    int a0;
    a0     = acc_n;
    tvalid = 1'b1;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    for (int i = 0; i < 40 && acc_n == a0; i++) tick();
    check("beat_accept", 512'(acc_n != a0), 512'(1));
  endtask

  task automatic drain();
    tvalid = 1'b0;
    tlast  = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    tick();
    check("drain_left", 512'(exp_q.size()), 512'(0));
    check("drain_rd_valid", 512'(rd_valid), 512'(0));
  endtask

  initial begin
    aresetn = 1'b0;
    tvalid  = 1'b0;
    tdata   = '0;
    tkeep   = '0;
    tlast   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;

    // Reset values
    #12;
    check("rst_tready",   512'(tready),       512'(1));
    check("rst_rd_valid", 512'(rd_valid),     512'(0));
    check("rst_rd_data",  rd_data,            512'(0));
    check("rst_rd_bytes", 512'(rd_bytes),     512'(0));
    check("rst_rd_last",  512'(rd_last),      512'(0));
    check("rst_rd_err",   512'(rd_err),       512'(0));
    check("rst_msg",      512'(msg_count),    512'(0));
    check("rst_err_ovl",  512'(err_overlong), 512'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Single 3-beat message, consumer always ready
    rd_en = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      exp_push(pat(n), 7'd64, n == 3, 1'b0);
      send_beat(pat(n), KEEP_ALL, n == 3);
    end
    drain();
    check("single_msg_count", 512'(msg_count), 512'(1));

    // Partial final beat: 5 valid bytes
    exp_push(pat(10), 7'd5, 1'b1, 1'b0);
    send_beat(pat(10), 64'h0000_0000_0000_001F, 1'b1);
    drain();
    check("partial_msg_count", 512'(msg_count), 512'(2));

    // Back-pressure: consumer stalled, FIFO of 4 fills
    rd_en = 1'b0;
    acc_n = 0;
    for (int n = 1; n <= 4; n++) begin
      exp_push(pat(20 + n), 7'd64, 1'b0, 1'b0);
      send_beat(pat(20 + n), KEEP_ALL, 1'b0);
    end
    check("bp_tready_full", 512'(tready), 512'(0));
    exp_push(pat(25), 7'd64, 1'b0, 1'b0);
    tvalid = 1'b1;
    tdata  = pat(25);
    tkeep  = KEEP_ALL;
    tlast  = 1'b0;
    tick();
    tick();
    check("bp_stalled_acc", 512'(acc_n), 512'(4));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("bp_tready_after_pop", 512'(tready), 512'(1));
    tick();
    check("bp_beat5_acc", 512'(acc_n), 512'(5));
    rd_en = 1'b1;
    exp_push(pat(26), 7'd64, 1'b1, 1'b0);
    send_beat(pat(26), KEEP_ALL, 1'b1);
    drain();
    check("bp_msg_count", 512'(msg_count), 512'(3));

    // Overlong: 20 beats, limit 16, beats 17..20 discarded
    rd_en = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      if (n >= 17) check("drop_tready", 512'(tready), 512'(1));
      if (n <= 16) exp_push(pat(100 + n), 7'd64, n == 16, n == 16);
      send_beat(pat(100 + n), KEEP_ALL, n == 20);
    end
    drain();
    check("ovl_flag", 512'(err_overlong), 512'(1));
    check("ovl_msg_count", 512'(msg_count), 512'(4));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovl_flag_cleared", 512'(err_overlong), 512'(0));

    // Eight back-to-back single-beat messages at full rate
    rd_en = 1'b1;
    begin
      int t0;
      t0 = tick_n;
      for (int n = 0; n < 8; n++) begin
        exp_push(pat(200 + n), 7'd64, 1'b1, 1'b0);
        send_beat(pat(200 + n), KEEP_ALL, 1'b1);
      end
      check("b2b_cycles", 512'(tick_n - t0), 512'(8));
    end
    drain();
    check("b2b_msg_count", 512'(msg_count), 512'(12));

    // Reset in the middle of a 5-beat message
    rd_en = 1'b0;
    send_beat(pat(301), KEEP_ALL, 1'b0);
    send_beat(pat(302), KEEP_ALL, 1'b0);
    tvalid  = 1'b0;
    aresetn = 1'b0;
    #1;
    check("mid_rst_tready",   512'(tready),       512'(1));
    check("mid_rst_rd_valid", 512'(rd_valid),     512'(0));
    check("mid_rst_rd_data",  rd_data,            512'(0));
    check("mid_rst_rd_bytes", 512'(rd_bytes),     512'(0));
    check("mid_rst_rd_last",  512'(rd_last),      512'(0));
    check("mid_rst_rd_err",   512'(rd_err),       512'(0));
    check("mid_rst_msg",      512'(msg_count),    512'(0));
    check("mid_rst_err_ovl",  512'(err_overlong), 512'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rd_en   = 1'b1;
    exp_push(pat(310), 7'd2, 1'b1, 1'b0);
    send_beat(pat(310), 64'h0000_0000_0000_0003, 1'b1);
    drain();
    check("post_rst_msg_count", 512'(msg_count), 512'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
